// File: rtl/mips_state_ctrl.sv
// Multicycle sequencer for the MIPS CPU: owns the FETCH/EXEC1/EXEC2/HALT
// state, the instruction register, load data and the retired counter.
module mips_state_ctrl #(
  parameter bit          SWAP_ENDIAN  = 1'b0,
  parameter logic [31:0] RETIRED_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        halt,
  input  logic        extra,
  output logic [1:0]  state,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic        active,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] instr_q;
  logic [31:0] load_q;
  logic [31:0] retired_q;
  logic        ld_instr;
  logic        ld_data;
  logic        retire;
  logic [31:0] rdata;

  assign rdata = SWAP_ENDIAN ?
    {readdata[7:0], readdata[15:8],
     readdata[23:16], readdata[31:24]} :
    readdata;

  always_comb begin
    state_d  = state_q;
    ld_instr = 1'b0;
    ld_data  = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      FETCH: begin
        // halt wins over a stalled fetch
        if (halt) begin
          state_d = HALT;
        end else if (!waitrequest) begin
          ld_instr = 1'b1;
          state_d  = EXEC1;
        end
      end
      EXEC1: begin
        if (!waitrequest) begin
          if (extra) begin
            ld_data = 1'b1;
            state_d = EXEC2;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      EXEC2: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instr_q   <= 32'h0;
      load_q    <= 32'h0;
      retired_q <= RETIRED_INIT;
    end else begin
      state_q <= state_d;
      if (ld_instr) instr_q <= rdata;
      if (ld_data) load_q <= rdata;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign state       = state_q;
  assign instruction = instr_q;
  assign load_data   = load_q;
  assign retired     = retired_q;
  assign active      = (state_q != HALT);

endmodule
